dccm_port_arbiter: RTL and testbench
====================================

# dccm_port_arbiter

Two-requester arbiter sharing the single-port DCCM SRAM between the core load/store unit (LSU) and a DMA/debug loader port. It sits between `rv32_x_wrapper`'s LSU and the DCCM macro. Each cycle it selects one winner, drives the SRAM from that requester, and routes the one-cycle-latency read data back to the requester that issued the read. The LSU has priority. A starvation counter forces a DMA grant after a bounded wait.

## Interface
- `ADDR_W`, 14, DCCM word-address width
- `DATA_W`, 32, data width; byte strobes are `DATA_W/8` bits wide
- `STARVE_LIMIT`, 4, number of consecutive denied DMA cycles before DMA is forced to win; legal range 1..15
- Clock and reset: clock `clk`; reset `rst_n`, asynchronous, active-low.
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous active-low reset
- `lsu_req`, `lsu_we`  in  1 each  LSU request valid, write enable
- `lsu_addr`  in  ADDR_W  LSU word address
- `lsu_wdata`  in  DATA_W  LSU write data
- `lsu_wstrb`  in  DATA_W/8  LSU byte strobes
- `lsu_gnt`  out  1  LSU request accepted this cycle
- `lsu_rvalid`  out  1  LSU read data valid
- `lsu_rdata`  out  DATA_W  LSU read data
- `dma_*`  same set as `lsu_*`, for the DMA port
- `sram_cs`, `sram_we`  out  1 each  SRAM chip select, write enable
- `sram_addr`  out  ADDR_W  SRAM address
- `sram_wdata`  out  DATA_W  SRAM write data
- `sram_wstrb`  out  DATA_W/8  SRAM byte strobes
- `sram_rdata`  in  DATA_W  SRAM read data, valid one cycle after a read with `cs=1, we=0`
- `conflict_cnt`  out  32  number of cycles in which both `lsu_req` and `dma_req` were high; wraps at 2^32

## Operation
- **Handshake:** a requester raises `req` and holds `we`, `addr`, `wdata` and `wstrb` stable until `gnt` is seen. A transfer completes on the cycle where `req && gnt`. Requests are never queued inside the arbiter.
- **Arbitration (combinational), two modes selected by the starvation count `starve_cnt`:**
  - **LSU_PRIO** (`starve_cnt < STARVE_LIMIT`): `lsu_req` wins; otherwise `dma_req` wins.
  - **DMA_FORCED** (`starve_cnt == STARVE_LIMIT`): `dma_req` wins even if `lsu_req` is high.
- **Grants:** at most one `gnt` is high per cycle. `gnt` is never asserted without the matching `req`.
- **SRAM drive:** `sram_cs = lsu_gnt | dma_gnt`. The other SRAM outputs are muxed from the winner. When idle they are driven to 0.
- **Starvation counter** (`$clog2(STARVE_LIMIT+1)` bits):
  - increments when `dma_req && !dma_gnt`, saturating at `STARVE_LIMIT`;
  - clears when `dma_gnt` or `!dma_req`.
- **Read response tracking:**
  - Registered `rd_owner` ∈ {NONE, LSU, DMA}. It is set at the grant of a read (`we=0`); it is NONE after a write or an idle cycle.
  - Next cycle: the owner's `rvalid=1` and its `rdata = sram_rdata`. The non-owner's `rdata` is 0.
  - Writes produce no `rvalid`.
- **Conflict counter:** `conflict_cnt` increments every cycle in which `lsu_req && dma_req`, regardless of the winner.

## Timing
- **Reset values:** all `gnt` and `rvalid` outputs 0, all `rdata` 0, all `sram_*` outputs 0, `rd_owner` = NONE, `starve_cnt` = 0, `conflict_cnt` = 0.
- **Grant latency:** 0 cycles; `gnt` is combinational from `req` and registered state.
- **Read latency:** `rvalid` is exactly 1 cycle after the grant. Back-to-back reads give a read every cycle.
- **Simultaneous requests:** with both requests held, the LSU wins `STARVE_LIMIT` cycles, then DMA wins 1 cycle, and the counter clears.
- **Reset mid-operation:** an in-flight read's `rvalid` is dropped, not replayed. Requesters re-issue after reset.
- **Grant decision inputs:** the same-cycle `rvalid` has no effect on grant decisions (independent pipeline stage).
- **`STARVE_LIMIT` bound:** DMA wait is bounded by `STARVE_LIMIT` cycles.

## Structure
- **Package `dccm_arb_pkg`:**
  - `owner_e` enum (NONE/LSU/DMA);
  - `arb_mode_e` enum (LSU_PRIO/DMA_FORCED);
  - `mem_req_t` struct (`req`, `we`, `addr`, `wdata`, `wstrb`), parameterised through `localparam`s `DCCM_ADDR_W=14` and `DCCM_DATA_W=32`.
- **Sub-module `dccm_arb_starve_ctr`:** the saturating counter. It outputs `force_dma` and is reused later for the ICCM loader port.
- **Top module:** grant logic, SRAM mux, response routing and the conflict counter.

## Test plan
- **LSU-only read:** `lsu_req=1, we=0, addr=0x010`, with `sram_rdata=0xDEADBEEF` next cycle → `lsu_gnt=1` the same cycle, `sram_cs=1, sram_addr=0x010`; next cycle `lsu_rvalid=1, lsu_rdata=0xDEADBEEF, dma_rvalid=0`.
- **Both requesting, DMA write** (`addr=0x020`, `wdata=0x12345678`, `wstrb=0xF`), `STARVE_LIMIT=4`, both held for 6 cycles → `lsu_gnt` in cycles 0–3; `dma_gnt` in cycle 4 with `sram_we=1, sram_wdata=0x12345678`; `lsu_gnt` in cycle 5. `conflict_cnt` reads 6 afterwards.
- **Alternating reads:** LSU read `0x001`, then DMA read `0x002` in consecutive cycles → `lsu_rvalid` in cycle 1, `dma_rvalid` in cycle 2, each with its own SRAM data; no cross-delivery.
- **DMA drop clears starvation:** DMA denied 3 cycles, drops `req` 1 cycle, then re-requests with the LSU busy → `starve_cnt` restarts at 0; DMA is granted only after 4 further denied cycles.
- **Reset mid-read:** LSU read granted, `rst_n=0` before the next edge → `lsu_rvalid` stays 0; all outputs and counters at reset values.
- **Write response:** LSU write to `0x3FFF` (the top address) → `lsu_gnt=1`, `sram_addr=0x3FFF`; no `rvalid` on the following cycle.

Source files
------------

// File: rtl/dccm_arb_pkg.sv
// Shared types and constants for the DCCM port arbiter.
//   owner_e    : which requester a registered read response belongs to
//   arb_mode_e : arbitration mode chosen by the DMA starvation state
//   mem_req_t  : one requester's request bundle at the default DCCM widths
package dccm_arb_pkg;

  localparam int DCCM_ADDR_W = 14;
  localparam int DCCM_DATA_W = 32;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    LSU  = 2'd1,
    DMA  = 2'd2
  } owner_e;

  typedef enum logic {
    LSU_PRIO   = 1'b0,
    DMA_FORCED = 1'b1
  } arb_mode_e;

  typedef struct packed {
    logic                       req;
    logic                       we;
    logic [DCCM_ADDR_W-1:0]     addr;
    logic [DCCM_DATA_W-1:0]     wdata;
    logic [DCCM_DATA_W/8-1:0]   wstrb;
  } mem_req_t;

endpackage

// File: rtl/dccm_port_arbiter_if.sv
// Requester-side memory port of the DCCM arbiter (one instance per requester).
//   req/we/addr/wdata/wstrb : request, held stable by the requester until gnt
//   gnt                     : request accepted this cycle
//   rvalid/rdata            : read response, one cycle after a read grant
// Modports: master = requester, slave = arbiter.
interface dccm_port_arbiter_if
  import dccm_arb_pkg::*;
#(
  parameter int ADDR_W = DCCM_ADDR_W,
  parameter int DATA_W = DCCM_DATA_W
) ();

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, wstrb,
                  input  gnt, rvalid, rdata);

  modport slave  (input  req, we, addr, wdata, wstrb,
                  output gnt, rvalid, rdata);

endinterface

// File: rtl/dccm_arb_starve_ctr.sv
// Saturating starvation counter for a low-priority requester.
//   clk, rst_n : clock, asynchronous active-low reset
//   req, gnt   : low-priority requester's request and grant this cycle
//   force_dma  : requester has been denied LIMIT consecutive cycles and must win
// Counts consecutive denied cycles, saturates at LIMIT, clears on grant or
// when the request is withdrawn.
module dccm_arb_starve_ctr
  import dccm_arb_pkg::*;
#(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic gnt,
  output logic force_dma
);

  localparam int             CW      = $clog2(LIMIT + 1);
  localparam logic [CW-1:0]  LIMIT_C = CW'(LIMIT);

  logic [CW-1:0] cnt;

  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge value of every other flop, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (req && !gnt) begin
      if (cnt != LIMIT_C) cnt <= cnt + 1'b1;
    end else begin
      cnt <= '0;
    end
  end

  assign force_dma = (cnt == LIMIT_C);

endmodule

// File: rtl/dccm_port_arbiter.sv
// Arbiter sharing the single-port DCCM SRAM between the LSU and the DMA/debug
// loader port. One winner per cycle; the LSU has priority except when the DMA
// starvation counter forces a DMA grant.
//   clk, rst_n   : clock, asynchronous active-low reset
//   lsu, dma     : requester ports (slave side of dccm_port_arbiter_if)
//   sram_*       : SRAM macro drive; sram_rdata valid one cycle after a read
//   conflict_cnt : cycles in which both requesters asked, wraps at 2^32
module dccm_port_arbiter
  import dccm_arb_pkg::*;
#(
  parameter int ADDR_W       = DCCM_ADDR_W,
  parameter int DATA_W       = DCCM_DATA_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  dccm_port_arbiter_if.slave  lsu,
  dccm_port_arbiter_if.slave  dma,
  output logic                sram_cs,
  output logic                sram_we,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [DATA_W-1:0]   sram_wdata,
  output logic [DATA_W/8-1:0] sram_wstrb,
  input  logic [DATA_W-1:0]   sram_rdata,
  output logic [31:0]         conflict_cnt
);

  logic      force_dma;
  arb_mode_e mode;
  logic      lsu_gnt;
  logic      dma_gnt;
  owner_e    rd_owner;
  owner_e    rd_owner_d;

  dccm_arb_starve_ctr #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (dma.req),
    .gnt       (dma_gnt),
    .force_dma (force_dma)
  );

  assign mode = force_dma ? DMA_FORCED : LSU_PRIO;

  // Grants are combinational from the requests; rst_n is folded in so that a
  // pending request cannot reach the SRAM while the block is held in reset.
  // NOTE: every always_comb output gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    lsu_gnt = 1'b0;
    dma_gnt = 1'b0;
    if (rst_n) begin
      case (mode)
        DMA_FORCED: begin
          dma_gnt = dma.req;
          lsu_gnt = lsu.req & ~dma.req;
        end
        default: begin
          lsu_gnt = lsu.req;
          dma_gnt = dma.req & ~lsu.req;
        end
      endcase
    end
  end

  assign lsu.gnt = lsu_gnt;
  assign dma.gnt = dma_gnt;

  // SRAM mux: winner's fields, all zero when idle.
  always_comb begin
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    sram_wstrb = '0;
    if (lsu_gnt) begin
      sram_we    = lsu.we;
      sram_addr  = lsu.addr;
      sram_wdata = lsu.wdata;
      sram_wstrb = lsu.wstrb;
    end else if (dma_gnt) begin
      sram_we    = dma.we;
      sram_addr  = dma.addr;
      sram_wdata = dma.wdata;
      sram_wstrb = dma.wstrb;
    end
  end

  assign sram_cs = lsu_gnt | dma_gnt;

  // Remember who issued this cycle's read so next cycle's SRAM data is routed
  // back to that requester only.
  always_comb begin
    rd_owner_d = NONE;
    if (lsu_gnt && !lsu.we)      rd_owner_d = LSU;
    else if (dma_gnt && !dma.we) rd_owner_d = DMA;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_owner <= NONE;
    else        rd_owner <= rd_owner_d;
  end

  assign lsu.rvalid = (rd_owner == LSU);
  assign dma.rvalid = (rd_owner == DMA);
  assign lsu.rdata  = (rd_owner == LSU) ? sram_rdata : '0;
  assign dma.rdata  = (rd_owner == DMA) ? sram_rdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  conflict_cnt <= '0;
    else if (lsu.req && dma.req) conflict_cnt <= conflict_cnt + 32'd1;
  end

endmodule

// File: tb/tb_dccm_port_arbiter.sv
// Self-checking bench for dccm_port_arbiter: directed scenarios followed by
// randomized requesters, checked by a reference model plus a read-response
// scoreboard drained by an independent monitor.
module tb_dccm_port_arbiter;
  import dccm_arb_pkg::*;

  localparam int AW    = DCCM_ADDR_W;
  localparam int DW    = DCCM_DATA_W;
  localparam int SW    = DW / 8;
  localparam int LIMIT = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          sram_cs, sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata = '0;
  logic [SW-1:0] sram_wstrb;
  logic [31:0]   conflict_cnt;

  dccm_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) lsu_if ();
  dccm_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) dma_if ();

  dccm_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .lsu          (lsu_if.slave),
    .dma          (dma_if.slave),
    .sram_cs      (sram_cs),
    .sram_we      (sram_we),
    .sram_addr    (sram_addr),
    .sram_wdata   (sram_wdata),
    .sram_wstrb   (sram_wstrb),
    .sram_rdata   (sram_rdata),
    .conflict_cnt (conflict_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cycle   = 0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                          input logic [SW-1:0] strb);
    merge = old;
    for (int b = 0; b < SW; b++) if (strb[b]) merge[8*b +: 8] = nw[8*b +: 8];
  endfunction

  // SRAM macro behaviour: one-cycle read latency, byte-strobed writes,
  // garbage on the read bus when no read was issued.
  logic [DW-1:0] sram_mem [0:2**AW-1];
  logic [DW-1:0] ref_mem  [0:2**AW-1];

  always @(posedge clk) begin
    if (sram_cs && !sram_we) sram_rdata <= sram_mem[sram_addr];
    else                     sram_rdata <= $urandom;
    if (sram_cs && sram_we)
      sram_mem[sram_addr] <= merge(sram_mem[sram_addr], sram_wdata, sram_wstrb);
  end

  // Reference model: LSU wins unless DMA has already been refused LIMIT
  // cycles in a row while asking.
  typedef struct {
    owner_e        own;
    logic [DW-1:0] data;
    int            due;
  } rsp_t;

  rsp_t     sb[$];
  int       dma_wait  = 0;
  int       conflicts = 0;
  logic     exp_l_gnt = 1'b0;
  logic     exp_d_gnt = 1'b0;
  mem_req_t m_lr, m_dr, m_w;
  logic     m_el, m_ed;

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_gnt",      {lsu_if.gnt, dma_if.gnt}, 64'd0);
      check("rst_rvalid",   {lsu_if.rvalid, dma_if.rvalid}, 64'd0);
      check("rst_rdata",    {lsu_if.rdata, dma_if.rdata}, 64'd0);
      check("rst_sram",     {sram_cs, sram_we, sram_addr, sram_wdata, sram_wstrb}, 64'd0);
      check("rst_conflict", conflict_cnt, 64'd0);
      dma_wait  = 0;
      conflicts = 0;
      exp_l_gnt = 1'b0;
      exp_d_gnt = 1'b0;
    end else begin
      m_lr = '{lsu_if.req, lsu_if.we, lsu_if.addr, lsu_if.wdata, lsu_if.wstrb};
      m_dr = '{dma_if.req, dma_if.we, dma_if.addr, dma_if.wdata, dma_if.wstrb};
      m_el = m_lr.req && !(m_dr.req && dma_wait >= LIMIT);
      m_ed = m_dr.req && !m_el;
      m_w  = m_el ? m_lr : (m_ed ? m_dr : '0);
      check("gnt", {lsu_if.gnt, dma_if.gnt}, {m_el, m_ed});
      check("sram_bus", {sram_cs, sram_we, sram_addr, sram_wdata, sram_wstrb},
            {m_el | m_ed, m_w.we, m_w.addr, m_w.wdata, m_w.wstrb});
      check("conflict_cnt", conflict_cnt, 64'(conflicts));
      if ((m_el || m_ed) && !m_w.we)
        sb.push_back('{m_el ? LSU : DMA, ref_mem[m_w.addr], cycle + 1});
      if ((m_el || m_ed) && m_w.we)
        ref_mem[m_w.addr] = merge(ref_mem[m_w.addr], m_w.wdata, m_w.wstrb);
      dma_wait  = (m_dr.req && !m_ed) ? dma_wait + 1 : 0;
      if (m_lr.req && m_dr.req) conflicts++;
      exp_l_gnt = m_el;
      exp_d_gnt = m_ed;
    end
  end

  // Monitor: every cycle either the head response is due and must appear on
  // exactly its owner's port, or neither port may show a response.
  rsp_t mon_r;
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
    end else if (sb.size() > 0 && sb[0].due == cycle) begin
      mon_r = sb.pop_front();
      check("rvalid", {lsu_if.rvalid, dma_if.rvalid}, {mon_r.own == LSU, mon_r.own == DMA});
      check("rdata", {lsu_if.rdata, dma_if.rdata},
            (mon_r.own == LSU) ? {mon_r.data, 32'h0} : {32'h0, mon_r.data});
    end else begin
      check("rvalid_idle", {lsu_if.rvalid, dma_if.rvalid}, 64'd0);
      check("rdata_idle",  {lsu_if.rdata, dma_if.rdata}, 64'd0);
    end
  end

  // ---------------- stimulus ----------------
  localparam mem_req_t IDLE = '0;

  function automatic mem_req_t rd(input int a);
    rd = '0; rd.req = 1'b1; rd.addr = AW'(a);
  endfunction

  function automatic mem_req_t wr(input int a, input logic [DW-1:0] d, input logic [SW-1:0] s);
    wr = '0; wr.req = 1'b1; wr.we = 1'b1; wr.addr = AW'(a); wr.wdata = d; wr.wstrb = s;
  endfunction

  function automatic mem_req_t rnd_req(input int pct);
    mem_req_t r;
    r.req   = ($urandom_range(0, 99) < pct);
    r.we    = ($urandom_range(0, 2) == 0);
    r.addr  = ($urandom_range(0, 9) == 0) ? '1 : AW'($urandom_range(0, 15));
    r.wdata = $urandom;
    r.wstrb = SW'($urandom);
    return r;
  endfunction

  task automatic apply(input mem_req_t l, input mem_req_t d);
    lsu_if.req = l.req; lsu_if.we = l.we; lsu_if.addr = l.addr;
    lsu_if.wdata = l.wdata; lsu_if.wstrb = l.wstrb;
    dma_if.req = d.req; dma_if.we = d.we; dma_if.addr = d.addr;
    dma_if.wdata = d.wdata; dma_if.wstrb = d.wstrb;
  endtask

  task automatic drive(input mem_req_t l, input mem_req_t d);
    apply(l, d);
    @(posedge clk); #1;
  endtask

  // Directed cycle with the grant pattern stated up front.
  task automatic drive_chk(input string name, input mem_req_t l, input mem_req_t d,
                           input logic lg, input logic dg);
    apply(l, d);
    @(negedge clk);
    check(name, {lsu_if.gnt, dma_if.gnt}, {lg, dg});
    @(posedge clk); #1;
  endtask

  mem_req_t lp, dp;

  initial begin
    for (int i = 0; i < 2**AW; i++) begin
      sram_mem[i] = DW'(i * 32'h0101_0007);
      ref_mem[i]  = DW'(i * 32'h0101_0007);
    end
    sram_mem[16] = 32'hDEAD_BEEF; ref_mem[16] = 32'hDEAD_BEEF;
    sram_mem[1]  = 32'hA5A5_0001; ref_mem[1]  = 32'hA5A5_0001;
    sram_mem[2]  = 32'h5A5A_0002; ref_mem[2]  = 32'h5A5A_0002;
    apply(IDLE, IDLE);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // LSU-only read of 0x010
    drive_chk("lsu_read_gnt", rd(16), IDLE, 1'b1, 1'b0);
    drive_chk("lsu_read_idle", IDLE, IDLE, 1'b0, 1'b0);

    // Both held 6 cycles: LSU x4, DMA write, LSU
    for (int i = 0; i < 6; i++)
      drive_chk("both_held", rd(5), wr(32, 32'h1234_5678, 4'hF), i != 4, i == 4);
    check("conflict_after_both", conflict_cnt, 64'd6);
    drive_chk("read_back_dma_wr", IDLE, rd(32), 1'b0, 1'b1);

    // Alternating reads, no cross-delivery
    drive_chk("alt_lsu", rd(1), IDLE, 1'b1, 1'b0);
    drive_chk("alt_dma", IDLE, rd(2), 1'b0, 1'b1);
    drive_chk("alt_idle", IDLE, IDLE, 1'b0, 1'b0);

    // DMA denied 3 cycles, drops, then waits 4 more before winning
    for (int i = 0; i < 3; i++) drive_chk("starve_pre", rd(3), rd(4), 1'b1, 1'b0);
    drive_chk("starve_drop", rd(3), IDLE, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) drive_chk("starve_post", rd(3), rd(4), i < 4, i == 4);

    // Write to the top address: no response
    drive_chk("top_write", wr(16'h3FFF, 32'hCAFE_F00D, 4'b0101), IDLE, 1'b1, 1'b0);
    drive_chk("top_write_idle", IDLE, IDLE, 1'b0, 1'b0);

    // Reset while a read is in flight
    apply(rd(16), IDLE);
    @(negedge clk);
    check("pre_reset_gnt", {lsu_if.gnt, dma_if.gnt}, 64'b10);
    #2 rst_n = 1'b0;
    apply(rd(16), rd(7));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    apply(IDLE, IDLE);

    // Randomized requesters that hold each request until granted
    lp = rnd_req(60);
    dp = rnd_req(80);
    for (int n = 0; n < 600; n++) begin
      drive(lp, dp);
      if (exp_l_gnt || !lp.req) lp = rnd_req(60);
      if (exp_d_gnt || !dp.req) dp = rnd_req(80);
    end

    drive(IDLE, IDLE);
    drive(IDLE, IDLE);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
